iter_divider: RTL

- Multi-cycle radix-2 restoring divider for the EX stage.
- Responder end of the ALU's divide start/done handshake: the ALU drives div_begin, operand magnitudes and sign flags; this block returns the signed-corrected quotient and remainder with a one-cycle div_done pulse.
- The ALU packs the results into HI/LO: HI = remainder, LO = quotient.

---
 rtl/iter_divider.sv | 126 ++++++++++++
 1 files changed

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider: unsigned magnitudes in, sign-corrected
// quotient/remainder out with a one-cycle done pulse after WIDTH+2 cycles.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_begin,
  input  logic             div_sign,
  input  logic             div_dividend_sign,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_done,
  output logic             div_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_quot_shift;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_prem;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_done;
  logic             r_busy;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  // Two's-complement negation, modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v);
    f_neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Trial subtraction for one restoring step; the trial is WIDTH+1 bits wide
  // but the stored remainder always fits in WIDTH bits since it is < divisor.
  always_comb begin
    w_trial = {r_prem, r_quot_shift[WIDTH-1]};
    w_diff  = w_trial - {1'b0, r_divisor};
    w_ge    = (w_trial >= {1'b0, r_divisor});
  end

  // Divider FSM with registered results, done pulse and busy flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_quot_shift <= '0;
      r_divisor    <= '0;
      r_prem       <= '0;
      r_cnt        <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_quotient   <= '0;
      r_remainder  <= '0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (div_begin) begin
            r_quot_shift <= div_dividend;
            r_divisor    <= div_divisor;
            r_neg_q      <= div_sign;
            r_neg_r      <= div_dividend_sign;
            r_prem       <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_CALC;
          end else begin
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        S_CALC: begin
          // Dividend bits shift out the top as quotient bits shift in below.
          r_quot_shift <= {r_quot_shift[WIDTH-2:0], w_ge};
          r_prem       <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
          r_cnt        <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH-1)) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          r_quotient  <= r_neg_q ? f_neg(r_quot_shift) : r_quot_shift;
          r_remainder <= r_neg_r ? f_neg(r_prem) : r_prem;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign div_quotient  = r_quotient;
  assign div_remainder = r_remainder;
  assign div_done      = r_done;
  assign div_busy      = r_busy;

endmodule
